// File: rtl/varredura_matriz.sv
// varredura_matriz -- column-multiplexed driver for a 5x7 LED matrix.
//
// A 35-bit pattern is scanned one column at a time. Each column stays lit for
// DIV_COL cycles and is followed by one blank cycle, so that row data never
// changes while a column is still driven (anti-ghosting). A one-entry shadow
// buffer lets a new frame be queued while the current one is being displayed.
// The queued frame is swapped in only at the frame boundary, so the picture
// never tears. An optional blink gates the rows off every BLINK_FRAMES frames.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   frame_in     pattern, bits [7c+6:7c] = rows 0..6 of column c, 1 = LED on
//   frame_valid  frame_in is valid this cycle
//   frame_ready  a frame is transferred when frame_valid && frame_ready at an edge
//   blink_en     enables blinking of the displayed frame
//   colunas      one-hot, active-high column select
//   linhas       active-low row drive for the selected column
//   frame_done   one-cycle pulse in the blank cycle that follows column 4
//
// Handshake: frame_valid/frame_ready follow strict valid/ready semantics. A
// transfer happens on every rising edge where both are high. frame_ready does
// not depend on frame_valid, and the source must hold frame_in stable while
// frame_valid is high and frame_ready is low.
module varredura_matriz #(
    parameter int DIV_COL      = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [34:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        blink_en,
    output logic [4:0]  colunas,
    output logic [6:0]  linhas,
    output logic        frame_done
);

    localparam int DW = (DIV_COL > 1) ? $clog2(DIV_COL) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [34:0] active_q, active_d;
    logic [34:0] shadow_q, shadow_d;
    logic        shadow_full_q, shadow_full_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;

    logic [6:0]  col_bits;
    logic        boundary;
    logic        accept;

    // Row pattern of the column currently being scanned.
    always_comb begin
        col_bits = 7'd0;
        case (col_q)
            3'd0:    col_bits = active_q[6:0];
            3'd1:    col_bits = active_q[13:7];
            3'd2:    col_bits = active_q[20:14];
            3'd3:    col_bits = active_q[27:21];
            3'd4:    col_bits = active_q[34:28];
            default: col_bits = 7'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        dwell_d       = dwell_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;

        colunas     = 5'b00000;
        linhas      = 7'b1111111;
        frame_ready = 1'b0;
        frame_done  = 1'b0;

        boundary = (state_q == BLANK) && (col_q == 3'd4);
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    // In IDLE nothing is on screen, so the frame goes straight to active.
                    active_d = frame_in;
                    state_d  = SCAN;
                    col_d    = 3'd0;
                    dwell_d  = '0;
                end
            end
            SCAN: begin
                colunas     = 5'b00001 << col_q;
                linhas      = (blink_en && phase_q) ? 7'b1111111 : ~col_bits;
                frame_ready = !shadow_full_q;
                accept      = frame_valid && frame_ready;
                if (dwell_q == DW'(DIV_COL - 1)) begin
                    state_d = BLANK;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            BLANK: begin
                // At the frame boundary the shadow drains on this edge, so a new
                // frame may be taken in at the same time.
                frame_ready = !shadow_full_q || boundary;
                frame_done  = boundary;
                accept      = frame_valid && frame_ready;
                state_d     = SCAN;
                col_d       = boundary ? 3'd0 : col_q + 3'd1;
                if (boundary && shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            shadow_d      = frame_in;
            shadow_full_d = 1'b1;
        end

        // Blink phase: disabled blink parks the counter so re-enable starts lit.
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_done) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            col_q         <= 3'd0;
            dwell_q       <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            dwell_q       <= dwell_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz with DIV_COL=4, BLINK_FRAMES=2.
// A frame-position model predicts the outputs every cycle; directed sequences
// add literal expectations at hand-computed offsets.
module tb_varredura_matriz;

    localparam int DIV = 4;
    localparam int BF  = 2;
    localparam int PER = 5 * (DIV + 1);

    logic        clk;
    logic        reset;
    logic [34:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        blink_en;
    logic [4:0]  colunas;
    logic [6:0]  linhas;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    varredura_matriz #(.DIV_COL(DIV), .BLINK_FRAMES(BF)) dut (
        .clk(clk),
        .reset(reset),
        .frame_in(frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .blink_en(blink_en),
        .colunas(colunas),
        .linhas(linhas),
        .frame_done(frame_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    typedef struct packed {
        logic [4:0] col;
        logic [6:0] lin;
        logic       rdy;
        logic       done;
    } exp_t;

    bit          m_running = 0;
    int          m_pos = 0;          // cycle index within the frame period
    logic [34:0] m_active = '0;
    logic [34:0] exp_q[$];           // frames accepted but not yet displayed
    int          m_blink_cnt = 0;    // frames finished since blink was enabled

    function automatic exp_t model_out();
        exp_t o;
        int col;
        logic [6:0] bits;
        logic [34:0] sh;
        o.col  = 5'd0;
        o.lin  = 7'h7F;
        o.rdy  = 1'b1;
        o.done = 1'b0;
        if (m_running) begin
            col = m_pos / (DIV + 1);
            if (m_pos % (DIV + 1) == DIV) begin
                o.done = (col == 4);
                o.rdy  = (exp_q.size() == 0) || (col == 4);
            end else begin
                o.col = 5'(1 << col);
                sh    = m_active >> (7 * col);
                bits  = sh[6:0];
                o.rdy = (exp_q.size() == 0);
                if (!(blink_en && ((m_blink_cnt / BF) % 2 == 1)))
                    o.lin = ~bits;
            end
        end
        return o;
    endfunction

    task automatic model_step();
        exp_t o;
        o = model_out();
        if (reset) begin
            m_running   = 0;
            m_pos       = 0;
            m_active    = '0;
            m_blink_cnt = 0;
            exp_q.delete();
        end else begin
            if (!blink_en) m_blink_cnt = 0;
            else if (o.done) m_blink_cnt = m_blink_cnt + 1;
            if (!m_running) begin
                if (frame_valid) begin
                    m_active  = frame_in;
                    m_running = 1;
                    m_pos     = 0;
                end
            end else begin
                if (m_pos == PER - 1 && exp_q.size() > 0) m_active = exp_q.pop_front();
                if (frame_valid && o.rdy) exp_q.push_back(frame_in);
                m_pos = (m_pos + 1) % PER;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (check_en) begin
            e = model_out();
            chk("model colunas", 32'(colunas), 32'(e.col));
            chk("model linhas", 32'(linhas), 32'(e.lin));
            chk("model frame_ready", 32'(frame_ready), 32'(e.rdy));
            chk("model frame_done", 32'(frame_done), 32'(e.done));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [34:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) chk("frame_done timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [34:0] stream_val(input int k);
        return 35'(k) * 35'h0_0F0F_0F0F + 35'h1_0000_0001;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int accepts;
        int k;
        bit rdy;
        logic [34:0] f_a, f_b;

        reset       = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        blink_en    = 1'b0;
        repeat (3) tick();
        check_en = 1;

        // Reset state
        chk("reset colunas", 32'(colunas), 32'h00);
        chk("reset linhas", 32'(linhas), 32'h7F);
        chk("reset frame_ready", 32'(frame_ready), 32'd1);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle colunas", 32'(colunas), 32'h00);

        // Column 2 pattern: first SCAN cycle is column 0, dark
        send_frame(35'(7'b0000100) << 14);
        chk("first scan colunas", 32'(colunas), 32'h01);
        chk("first scan linhas", 32'(linhas), 32'h7F);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 4) chk("blank colunas", 32'(colunas), 32'h00);
        end
        chk("col2 colunas", 32'(colunas), 32'h04);
        chk("col2 linhas", 32'(linhas), 32'h7B);

        // Frame period
        wait_done(n);
        wait_done(n);
        chk("frame period", 32'(n), 32'(PER));

        // Double buffering: A into shadow mid-scan, B waits for the boundary
        f_a = 35'h5_5AA5_3C3C;
        f_b = 35'h2_C3C3_0FF0;
        tick();
        send_frame(f_a);
        chk("ready after accept", 32'(frame_ready), 32'd0);
        frame_in    = f_b;
        frame_valid = 1'b1;
        n = 0;
        while (!frame_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready returns in boundary blank", 32'(frame_done), 32'd1);
        tick();
        frame_valid = 1'b0;
        chk("ready after boundary fill", 32'(frame_ready), 32'd0);
        repeat (60) tick();

        // Blink with an all-ones frame
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        blink_en = 1'b1;
        send_frame({35{1'b1}});
        chk("blink lit frame0", 32'(linhas), 32'h00);
        repeat (50) tick();
        chk("blink dark colunas", 32'(colunas), 32'h01);
        chk("blink dark frame2", 32'(linhas), 32'h7F);
        repeat (50) tick();
        chk("blink lit frame4", 32'(linhas), 32'h00);
        repeat (50) tick();
        chk("blink dark frame6", 32'(linhas), 32'h7F);
        tick();
        blink_en = 1'b0;
        #1;
        chk("blink disable lit", 32'(linhas), 32'h00);
        repeat (10) tick();

        // Reset during column 3 with the shadow full
        do_reset();
        send_frame(35'h7_FFFF_FFFF);
        send_frame(35'h1_2345_6789);
        n = 0;
        while (colunas != 5'b01000 && n < 100) begin
            tick();
            n++;
        end
        chk("reached column 3", 32'(colunas), 32'h08);
        reset       = 1'b1;
        frame_in    = 35'h0_7777_7777;
        frame_valid = 1'b1;
        tick();
        reset       = 1'b0;
        frame_valid = 1'b0;
        chk("midscan reset colunas", 32'(colunas), 32'h00);
        chk("midscan reset linhas", 32'(linhas), 32'h7F);
        chk("midscan reset frame_ready", 32'(frame_ready), 32'd1);
        repeat (60) tick();
        chk("stays idle after reset", 32'(colunas), 32'h00);

        // Continuous frame_valid: one frame per boundary
        do_reset();
        accepts = 0;
        k = 0;
        for (int c = 0; c < 101; c++) begin
            frame_in    = stream_val(k);
            frame_valid = 1'b1;
            rdy = frame_ready;
            tick();
            if (rdy) begin
                accepts++;
                k++;
            end
        end
        frame_valid = 1'b0;
        chk("stream accepts", 32'(accepts), 32'd6);
        repeat (60) tick();

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/varredura_matriz.md
VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

Interface
REQ-001 Parameter DIV_COL, default 1000: clock cycles each column stays lit.
REQ-002 Parameter BLINK_FRAMES, default 50: frames per blink half-period.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_in  input  35  pattern; bits [7c+6:7c] = rows 0..6 of column c (c=0..4); 1 = LED on.
REQ-006 frame_valid  input  1  frame_in is valid this cycle.
REQ-007 frame_ready  output  1  block can accept a frame; transfer occurs when frame_valid && frame_ready at a rising edge.
REQ-008 blink_en  input  1  enables blinking of the displayed frame.
REQ-009 colunas  output  5  one-hot active-high column select to the 5x7 matrix.
REQ-010 linhas  output  7  active-low row drive for the selected column (0 = lit).
REQ-011 frame_done  output  1  one-cycle pulse on completion of each full 5-column scan.

Function
REQ-012 States SHALL be IDLE, SCAN and BLANK.
REQ-013 IDLE: colunas=5'b00000, linhas=7'b1111111, frame_ready=1; an accepted frame SHALL load the active buffer directly, and the next cycle SHALL be SCAN at column 0.
REQ-014 SCAN: colunas has only bit c set; linhas = ~active[7c+6:7c]; dwell counter counts 0..DIV_COL-1, and on DIV_COL-1 the next state SHALL be BLANK.
REQ-015 BLANK (anti-ghosting) SHALL last exactly one cycle with colunas=0 and linhas=7'b1111111, after which SCAN resumes at c+1, or at 0 after column 4.
REQ-016 Frame period SHALL be exactly 5*(DIV_COL+1) cycles.
REQ-017 frame_done SHALL pulse during the BLANK cycle that follows column 4.
REQ-018 Outside IDLE, frames SHALL be accepted into a one-entry shadow buffer; frame_ready = shadow empty.
REQ-019 Shadow SHALL move to active only at the BLANK following column 4 (frame boundary); the displayed frame never changes mid-scan.
REQ-020 When the shadow fills and empties at the same edge (BLANK after column 4 with frame_valid && frame_ready), both SHALL occur: old shadow to active, new frame to shadow.
REQ-021 With the shadow empty at a frame boundary, the active frame SHALL repeat.
REQ-022 Blink: a frame counter increments on each frame_done and wraps at BLINK_FRAMES-1, toggling a phase bit on wrap; with blink_en=1 and phase=1, linhas SHALL be 7'b1111111 during SCAN, while colunas keeps scanning.
REQ-023 With blink_en=0, phase SHALL be forced to 0 and the counter held at 0; on re-enable, the display starts in the on-phase.
REQ-024 The dwell counter SHALL be wide enough for DIV_COL-1 with no wrap; DIV_COL >= 1 is required.

Reset
REQ-025 At reset: state=IDLE, colunas=0, linhas=7'b1111111, frame_ready=1, frame_done=0, shadow empty, active=0, counters=0, blink phase=0.
REQ-026 Reset asserted mid-scan SHALL take effect at the next edge, discarding the active and shadow frames; a frame_valid coincident with reset SHALL be ignored.

Verification (DIV_COL=4, BLINK_FRAMES=2)
REQ-027 Reset, then a frame with column 2 = 7'b0000100 and all other columns 0 -> 1 cycle later colunas=00001 and linhas=1111111 for 4 cycles; BLANK; columns 1 and 2 follow, with linhas=1111011 while colunas=00100.
REQ-028 Frame period check -> frame_done pulses every 25 cycles; exactly one cycle of colunas=0 between consecutive columns.
REQ-029 Second frame B offered mid-scan of frame A -> frame_ready drops after accept; A completes unchanged; B displays from the next column 0; frame_ready returns to 1 in the BLANK cycle.
REQ-030 blink_en=1 with an all-ones frame -> 2 frames lit (linhas=0000000), 2 frames dark (linhas=1111111), repeating; blink_en=0 -> lit in the next SCAN cycle.
REQ-031 reset pulsed during column 3 with the shadow full -> next cycle IDLE, outputs at reset values; the old frame is never displayed again.
REQ-032 frame_valid held high continuously -> exactly one frame accepted per frame boundary (simultaneous drain and fill, REQ-020), with no lost or duplicated frames.
